// File: rtl/btn_pulse_gen_if.sv
// Button front-end signal bundle: raw pins in, debounced levels and press pulses out.
// The master side drives btn_raw, and the slave side (the front-end) drives everything else.
interface btn_pulse_gen_if;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic       mode_toggle_p;
    logic       paris_p;
    logic       ny_p;
    logic       uk_p;
    logic       korea_p;

    // No handshake here: btn_raw is sampled on every clock edge.
    // Each *_p output is high for exactly one cycle per accepted press.
    modport master (
        output btn_raw,
        input  btn_level, mode_toggle_p, paris_p, ny_p, uk_p, korea_p
    );

    modport slave (
        input  btn_raw,
        output btn_level, mode_toggle_p, paris_p, ny_p, uk_p, korea_p
    );
endinterface

// File: rtl/btn_pulse_gen.sv
// Five-button synchronizer/debouncer with registered press pulses.
// At most one city pulse fires per cycle, chosen by the fixed priority korea > paris > ny > uk.
module btn_pulse_gen #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned CNT_W      = 20,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    btn_pulse_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [4:0]       pressed;
    logic [4:0]       s1, s2, db, db_d;
    logic [CNT_W-1:0] cnt [5];
    logic [4:0]       rise;
    logic [4:0]       pulse_next;
    logic [4:0]       pulse_q;

    assign pressed = bus.btn_raw ^ {5{ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            s1   <= pressed;
            s2   <= s1;
            db_d <= db;
            // Any return to the accepted level discards the partial count.
            for (int i = 0; i < 5; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = db & ~db_d;

    // Bit order {korea, uk, ny, paris, mode}. Losing cities are dropped, not deferred.
    always_comb begin
        pulse_next    = '0;
        pulse_next[0] = rise[0];
        if (rise[4])      pulse_next[4] = 1'b1;
        else if (rise[1]) pulse_next[1] = 1'b1;
        else if (rise[2]) pulse_next[2] = 1'b1;
        else if (rise[3]) pulse_next[3] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pulse_q <= '0;
        else     pulse_q <= pulse_next;
    end

    assign bus.btn_level     = db;
    assign bus.mode_toggle_p = pulse_q[0];
    assign bus.paris_p       = pulse_q[1];
    assign bus.ny_p          = pulse_q[2];
    assign bus.uk_p          = pulse_q[3];
    assign bus.korea_p       = pulse_q[4];
endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen with DEB_CYCLES=4: a segment table of {rst, raw, cycles, expected level/pulses}
// plus hand-written glitch and re-press sequences, all checked through an expected-value queue.
module tb_btn_pulse_gen;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   cyc;

    logic [9:0] exp_q[$];

    btn_pulse_gen_if bus ();

    btn_pulse_gen #(
        .DEB_CYCLES(4),
        .CNT_W     (20),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bits are {korea, uk, ny, paris, mode}, the same order as btn_raw.
    typedef struct {
        logic       rst;
        logic [4:0] raw;
        int         n;
        logic [4:0] lvl;
        logic [4:0] pls;
    } seg_t;

    localparam int NSEG = 34;
    seg_t tbl [NSEG];

    // ---------------- driver + scoreboard ----------------
    // Drive one cycle of inputs, push the expected outputs, and after the edge pop and compare.
    task automatic step(input logic r, input logic [4:0] raw, input logic [4:0] lvl,
                        input logic [4:0] pls, input string name);
        logic [9:0] got;
        logic [9:0] want;
        rst         = r;
        bus.btn_raw = raw;
        exp_q.push_back({lvl, pls});
        @(posedge clk);
        #1;
        cyc++;
        got  = {bus.btn_level, bus.korea_p, bus.uk_p, bus.ny_p, bus.paris_p, bus.mode_toggle_p};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got level=%b pulses=%b, want level=%b pulses=%b",
                     name, cyc, got[9:5], got[4:0], want[9:5], want[4:0]);
        end
        n_cmp++;
        if ($countones(got[4:1]) > 1) begin
            n_fail++;
            $display("FAIL %s_one_city cycle %0d: got city pulses=%b, want at most one set",
                     name, cyc, got[4:1]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        cyc         = 0;
        rst         = 1'b1;
        bus.btn_raw = '0;

        tbl = '{
            // clean paris press, 12 cycles held, then release
            '{1'b0, 5'b00010, 5, 5'b00000, 5'b00000},
            '{1'b0, 5'b00010, 1, 5'b00010, 5'b00000},
            '{1'b0, 5'b00010, 1, 5'b00010, 5'b00010},
            '{1'b0, 5'b00010, 5, 5'b00010, 5'b00000},
            '{1'b0, 5'b00000, 5, 5'b00010, 5'b00000},
            '{1'b0, 5'b00000, 3, 5'b00000, 5'b00000},
            // ny bounce: 3 high, 1 low, then held
            '{1'b0, 5'b00100, 3, 5'b00000, 5'b00000},
            '{1'b0, 5'b00000, 1, 5'b00000, 5'b00000},
            '{1'b0, 5'b00100, 5, 5'b00000, 5'b00000},
            '{1'b0, 5'b00100, 1, 5'b00100, 5'b00000},
            '{1'b0, 5'b00100, 1, 5'b00100, 5'b00100},
            '{1'b0, 5'b00100, 4, 5'b00100, 5'b00000},
            '{1'b0, 5'b00000, 5, 5'b00100, 5'b00000},
            '{1'b0, 5'b00000, 3, 5'b00000, 5'b00000},
            // korea and ny together: korea wins, ny is dropped
            '{1'b0, 5'b10100, 5, 5'b00000, 5'b00000},
            '{1'b0, 5'b10100, 1, 5'b10100, 5'b00000},
            '{1'b0, 5'b10100, 1, 5'b10100, 5'b10000},
            '{1'b0, 5'b10100, 5, 5'b10100, 5'b00000},
            '{1'b0, 5'b00000, 5, 5'b10100, 5'b00000},
            '{1'b0, 5'b00000, 3, 5'b00000, 5'b00000},
            // mode and uk together: both pulse
            '{1'b0, 5'b01001, 5, 5'b00000, 5'b00000},
            '{1'b0, 5'b01001, 1, 5'b01001, 5'b00000},
            '{1'b0, 5'b01001, 1, 5'b01001, 5'b01001},
            '{1'b0, 5'b01001, 5, 5'b01001, 5'b00000},
            '{1'b0, 5'b00000, 5, 5'b01001, 5'b00000},
            '{1'b0, 5'b00000, 3, 5'b00000, 5'b00000},
            // uk held, reset at edge 5, one pulse counted from the first post-reset edge
            '{1'b0, 5'b01000, 4, 5'b00000, 5'b00000},
            '{1'b1, 5'b01000, 1, 5'b00000, 5'b00000},
            '{1'b0, 5'b01000, 5, 5'b00000, 5'b00000},
            '{1'b0, 5'b01000, 1, 5'b01000, 5'b00000},
            '{1'b0, 5'b01000, 1, 5'b01000, 5'b01000},
            '{1'b0, 5'b01000, 4, 5'b01000, 5'b00000},
            '{1'b0, 5'b00000, 5, 5'b01000, 5'b00000},
            '{1'b0, 5'b00000, 3, 5'b00000, 5'b00000}
        };

        // reset with random buttons: everything stays 0
        for (int i = 0; i < 3; i++) step(1'b1, 5'($urandom_range(0, 31)), 5'b0, 5'b0, "reset");
        for (int i = 0; i < 2; i++) step(1'b0, 5'b0, 5'b0, 5'b0, "idle");

        for (int s = 0; s < NSEG; s++)
            for (int k = 0; k < tbl[s].n; k++)
                step(tbl[s].rst, tbl[s].raw, tbl[s].lvl, tbl[s].pls, $sformatf("seg%0d", s));

        // short glitches (1..3 cycles, random button) never change the level
        for (int len = 1; len <= 3; len++) begin
            logic [4:0] b;
            b = 5'b00001 << $urandom_range(0, 4);
            for (int k = 0; k < len; k++) step(1'b0, b, 5'b0, 5'b0, "glitch");
            for (int k = 0; k < 8; k++)   step(1'b0, 5'b0, 5'b0, 5'b0, "glitch");
        end

        // press, release, press again at the maximum rate: two paris pulses
        for (int k = 1; k <= 32; k++) begin
            logic r, l, p;
            r = (k <= 6) || (k >= 13 && k <= 24);
            l = (k >= 6 && k < 12) || (k >= 18 && k < 30);
            p = (k == 7) || (k == 19);
            step(1'b0, {3'b0, r, 1'b0}, {3'b0, l, 1'b0}, {3'b0, p, 1'b0}, "repress");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/btn_pulse_gen.md
# btn_pulse_gen

Button front-end for the world-clock time-zone/mode control path. It synchronizes and debounces the five raw push-button inputs. It emits the single-cycle press pulses `mode_toggle_p`, `paris_p`, `ny_p`, `uk_p` and `korea_p` that the time-zone/mode controller consumes. It sits between the board pins and that controller, and guarantees at most one city pulse per cycle.

## Interface
- `DEB_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range 1 .. 2^CNT_W-1
- `CNT_W`, default 20: debounce counter width
- `ACTIVE_LOW`, default 0: 1 = raw buttons read 0 when pressed

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `btn_raw`  in  5  asynchronous raw buttons; bit0 mode, bit1 paris, bit2 ny, bit3 uk, bit4 korea
- `btn_level`  out  5  debounced pressed state, same bit map
- `mode_toggle_p`  out  1  one-cycle pulse on debounced mode press
- `paris_p`  out  1  one-cycle pulse on debounced paris press
- `ny_p`  out  1  one-cycle pulse on debounced ny press
- `uk_p`  out  1  one-cycle pulse on debounced uk press
- `korea_p`  out  1  one-cycle pulse on debounced korea press

## Operation
- Per channel i: `pressed = btn_raw[i] ^ ACTIVE_LOW` feeds a 2-flop synchronizer `s1 -> s2`.
- Debounce, per channel: `db` (the debounced level) and `cnt[CNT_W-1:0]`.
  - `s2 == db`: `cnt <= 0`.
  - `s2 != db` and `cnt == DEB_CYCLES-1`: `db <= s2`, `cnt <= 0`.
  - otherwise: `cnt <= cnt + 1`.
  - `cnt` never wraps.
  - Any return of `s2` to `db` before acceptance clears `cnt`. The glitch is discarded and has no partial credit.
- `btn_level[i] = db[i]`, driven straight from the register.
- Rise detect: `rise[i] = db[i] & ~db_d[i]`, where `db_d` is `db` delayed one cycle. A release (1->0) never produces a pulse.
- City arbitration among rises in the same cycle uses fixed priority korea > paris > ny > uk.
  - Only the winner pulses.
  - Losers are dropped, not deferred.
- The mode pulse is independent of the city pulses. It may coincide with a city pulse.
- All pulse outputs are registered. Each is high for exactly one cycle per accepted press. Holding a button produces no repeat pulses.
- Reset (synchronous, any cycle):
  - `s1`, `s2`, `db`, `db_d`, `cnt` and all pulses go to 0.
  - Any in-progress count is abandoned and emits no pulse.
- A button held through reset is treated as a new press after reset release. It yields exactly one pulse.

## Timing
- Reset values: `btn_level = 5'b0`; all `*_p = 0`.
- Let edge 1 be the first rising edge sampling a clean, held press (`rst` low).
  - `s2 = 1` after edge 2.
  - `db` and `btn_level` rise after edge `DEB_CYCLES+2`.
  - The pulse is high after edge `DEB_CYCLES+3` and low again after edge `DEB_CYCLES+4`.
- Release is symmetric: `btn_level` falls `DEB_CYCLES+2` edges after the first released sample. No pulse.
- A raw pulse shorter than `DEB_CYCLES` cycles at `s2` never changes `btn_level`.
- A press held across `rst` deassertion: count edge 1 as the first edge with `rst` low. Timing is then the same as above.
- Maximum output rate: one pulse per channel per `2*DEB_CYCLES+4` cycles (a press, then a release, then a press).

## Test plan
All scenarios use `DEB_CYCLES=4`, `ACTIVE_LOW=0`.
- Reset: hold `rst` 3 cycles with random `btn_raw` -> `btn_level=0` and all pulses 0 throughout.
- Clean press: paris held from edge 1 for 12 cycles -> `btn_level[1]` rises after edge 6, `paris_p` high only after edge 7. On release, `btn_level[1]` falls 6 edges later with no pulse.
- Bounce: ny 1 for 3 cycles, 0 for 1 cycle, then 1 held -> no pulse from the first burst. `ny_p` fires 7 edges after the final rise, exactly once.
- Simultaneous cities: korea and ny rise on the same edge -> `korea_p` pulses, `ny_p` stays 0 for the whole hold, and `btn_level[4]` and `btn_level[2]` are both 1.
- Mode plus city: mode and uk rise together -> `mode_toggle_p` and `uk_p` pulse in the same cycle.
- Reset mid-count: uk held, `rst` pulsed at edge 5, button kept held -> no pulse before reset. One `uk_p` pulse 7 edges after the first post-reset edge.
